tt_vmem_alloc_ctrl: RTL
=======================

# tt_vmem_alloc_ctrl

Issue-side allocation controller for the vector memory scoreboard and load queue. Accepts one memory-op request at a time and claims the lowest free scoreboard ID (0..31). It then sequences that op's load-queue entry allocations, one per cycle, through an 8-entry circular load queue, driving the scoreboard's allocation strobe, next lqid and first/last-allocation flags. It reclaims scoreboard IDs on completion and load-queue entries on commit.

## Interface
- SB_DEPTH, 32, number of scoreboard IDs (ID width = 5)
- LQ_DEPTH, 8, number of load-queue entries (lqid width = 3)
- MAX_BEATS, 8, maximum lq entries per request
- clk  in  1  clock
- reset  in  1  reset; one clock, reset is asynchronous and active-high
- i_req_valid  in  1  memop request pending
- o_req_ready  out  1  request accepted when high with i_req_valid
- i_req_beats  in  4  lq entries needed (legal 1..8)
- o_sb_id  out  5  scoreboard ID owned by current/last request
- o_lqalloc  out  1  lq allocation strobe (one entry this cycle)
- o_lqnxtid  out  3  lqid being allocated
- o_first_alloc  out  1  first beat of current request
- o_last_alloc  out  1  final beat of current request
- i_lq_commit  in  1  one lq entry retired (in order)
- i_completed_valid  in  1  scoreboard entry completed
- i_completed_sb_id  in  5  ID to release
- o_sb_free_count  out  6  free scoreboard IDs (0..32)
- o_lq_free_count  out  4  free lq entries (0..8)
- o_busy  out  1  FSM in ALLOC
- o_err  out  2  [0] ID double release, [1] commit underflow (TT_ALLOC_CHECK_EN only, else 0)

## Operation
- State: sb_free[31:0] vector, lq_head[2:0], lq_free_count, beats_left, beat_idx, FSM {IDLE, ALLOC}.
- o_req_ready = (state==IDLE) && (sb_free != 0); combinational.
- Accept (valid && ready): register o_sb_id = lowest set bit of sb_free, clear that bit, load beats_left = clamped beats (0 -> 1, >8 -> 8), beat_idx = 0, go ALLOC.
- ALLOC: o_lqalloc = (lq_free_count != 0). On strobe: o_lqnxtid = lq_head, o_first_alloc = (beat_idx==0), o_last_alloc = (beats_left==1); lq_head++ mod 8; beats_left--; beat_idx++; lq_free_count--. If lq_free_count==0, stall with all strobes low.
- After the cycle carrying o_last_alloc: return to IDLE.
- Release: i_completed_valid sets sb_free[i_completed_sb_id]. Release of an already-free ID is ignored.
- Commit: i_lq_commit increments lq_free_count. Commit while count==8 is ignored.
- Same-cycle alloc + commit: count unchanged. Same-cycle claim + release: claim uses the pre-edge sb_free, so the released ID is selectable only from the next cycle.
- o_sb_free_count = popcount(sb_free); o_lq_free_count registered.

## Timing
- Reset values: state IDLE, sb_free all ones, o_req_ready 1, o_sb_id 0, lq_head 0, o_lqnxtid 0, o_lqalloc/o_first_alloc/o_last_alloc 0, o_sb_free_count 32, o_lq_free_count 8, o_busy 0, o_err 0.
- Request accepted at edge T: first o_lqalloc visible in cycle T+1.
- An N-beat request with no stalls holds ALLOC for N cycles. The next request can be accepted in the cycle after last_alloc.
- The 1-beat request asserts first_alloc and last_alloc together.
- Reset asserted mid-ALLOC: immediate return to reset values; the partial allocation is abandoned.
- Free counts reflect commits/releases one cycle after the input strobe.

## Configuration
- TT_ALLOC_CHECK_EN defined:
  - o_err[0] sets (sticky until reset) on release of an already-free ID.
  - o_err[1] sets (sticky until reset) on commit with lq_free_count==8.
  - Simulation assertion fires on each event.
- Undefined: o_err tied to 0; illegal events are silently ignored as above.

## Test plan
- Reset, then 3-beat request: ready=1; sb_id 0; lqalloc for 3 cycles with lqnxtid 0,1,2; first on 0, last on 2; lq_free_count 5; o_busy low afterwards.
- 1-beat request: single lqalloc cycle with first and last both 1.
- Two 8-beat requests, no commits: second request stalls with lqalloc 0 until 8 commits arrive. Allocations then resume at lqnxtid 0 (wrap-around) with first_alloc asserted.
- Allocate 32 IDs (1 beat each, with commits): ready drops with o_sb_free_count 0. Release ID 17: ready rises the next cycle and the next claim gets ID 17.
- Same-cycle lqalloc and commit at lq_free_count 4: stays 4. Release of free ID 5: ignored; with TT_ALLOC_CHECK_EN, o_err=2'b01.
- Reset asserted mid-ALLOC (2 of 5 beats done): all outputs return to reset values; the next request gets sb_id 0 and lqnxtid 0.

Source files
------------

// File: rtl/tt_vmem_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// tt_vmem_alloc_ctrl
//   Issue-side allocation controller for the vector memory scoreboard and the
//   load queue. One memory-op request is accepted at a time. Each accepted
//   request claims the lowest free scoreboard ID. The controller then hands out
//   that op's load-queue entries from a circular load queue, one per cycle.
//   Scoreboard IDs are reclaimed on completion. Load-queue entries are
//   reclaimed on in-order commit.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   i_req_valid/o_req_ready, i_req_beats
//                       request handshake and the number of lq entries wanted
//                       (0 is treated as 1, values above MAX_BEATS as MAX_BEATS)
//   o_sb_id             scoreboard ID owned by the current/last request
//   o_lqalloc, o_lqnxtid, o_first_alloc, o_last_alloc
//                       per-beat lq allocation strobe, lqid and beat flags
//   i_lq_commit         one lq entry retired
//   i_completed_valid, i_completed_sb_id
//                       scoreboard ID release
//   o_sb_free_count, o_lq_free_count
//                       free scoreboard IDs / free lq entries
//   o_busy              allocation sequence in progress
//   o_err               [0] double release of an ID, [1] commit underflow
//
// Configuration
//   TT_ALLOC_CHECK_EN   when defined, o_err holds sticky error flags and
//                       simulation assertions flag each illegal event;
//                       otherwise o_err is 0 and illegal events are ignored.
// -----------------------------------------------------------------------------
module tt_vmem_alloc_ctrl #(
  parameter int SB_DEPTH  = 32,
  parameter int LQ_DEPTH  = 8,
  parameter int MAX_BEATS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [3:0]                    i_req_beats,
  output logic [$clog2(SB_DEPTH)-1:0]   o_sb_id,
  output logic                          o_lqalloc,
  output logic [$clog2(LQ_DEPTH)-1:0]   o_lqnxtid,
  output logic                          o_first_alloc,
  output logic                          o_last_alloc,
  input  logic                          i_lq_commit,
  input  logic                          i_completed_valid,
  input  logic [$clog2(SB_DEPTH)-1:0]   i_completed_sb_id,
  output logic [$clog2(SB_DEPTH+1)-1:0] o_sb_free_count,
  output logic [$clog2(LQ_DEPTH+1)-1:0] o_lq_free_count,
  output logic                          o_busy,
  output logic [1:0]                    o_err
);

  localparam int SB_W  = $clog2(SB_DEPTH);
  localparam int SBC_W = $clog2(SB_DEPTH + 1);
  localparam int LQ_W  = $clog2(LQ_DEPTH);
  localparam int LQC_W = $clog2(LQ_DEPTH + 1);

  typedef enum logic {S_IDLE, S_ALLOC} state_e;

  state_e             state_q, state_d;
  logic [SB_DEPTH-1:0] sb_free_q, sb_free_d;
  logic [SB_W-1:0]    sb_id_q, sb_id_d;
  logic [LQ_W-1:0]    lq_head_q, lq_head_d;
  logic [LQC_W-1:0]   lq_free_q, lq_free_d;
  logic [3:0]         beats_left_q, beats_left_d;
  logic [3:0]         beat_idx_q, beat_idx_d;

  logic [SB_W-1:0]    claim_id;
  logic               claim_found;
  logic [SBC_W-1:0]   sb_cnt;
  logic [3:0]         beats_clamped;
  logic               accept;
  logic               alloc;
  logic               commit_ok;

  // Lowest free ID and free-ID population count, both from the registered vector.
  always_comb begin
    claim_id    = '0;
    claim_found = 1'b0;
    sb_cnt      = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (sb_free_q[i] && !claim_found) begin
        claim_id    = SB_W'(i);
        claim_found = 1'b1;
      end
      sb_cnt = sb_cnt + SBC_W'(sb_free_q[i]);
    end
  end

  always_comb begin
    if (i_req_beats == 4'd0)
      beats_clamped = 4'd1;
    else if (i_req_beats > 4'(MAX_BEATS))
      beats_clamped = 4'(MAX_BEATS);
    else
      beats_clamped = i_req_beats;
  end

  assign o_req_ready = (state_q == S_IDLE) && claim_found;
  assign accept      = i_req_valid && o_req_ready;
  assign alloc       = (state_q == S_ALLOC) && (lq_free_q != '0);
  assign commit_ok   = i_lq_commit && (lq_free_q != LQC_W'(LQ_DEPTH));

  always_comb begin
    state_d      = state_q;
    sb_free_d    = sb_free_q;
    sb_id_d      = sb_id_q;
    lq_head_d    = lq_head_q;
    lq_free_d    = lq_free_q;
    beats_left_d = beats_left_q;
    beat_idx_d   = beat_idx_q;

    // Release is applied before the claim so that an ID released and claimed
    // in the same cycle (necessarily already free) ends up owned.
    if (i_completed_valid)
      sb_free_d[i_completed_sb_id] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sb_free_d[claim_id] = 1'b0;
          sb_id_d             = claim_id;
          beats_left_d        = beats_clamped;
          beat_idx_d          = '0;
          state_d             = S_ALLOC;
        end
      end
      S_ALLOC: begin
        if (alloc) begin
          lq_head_d    = (lq_head_q == LQ_W'(LQ_DEPTH - 1)) ? '0 : lq_head_q + 1'b1;
          beats_left_d = beats_left_q - 4'd1;
          beat_idx_d   = beat_idx_q + 4'd1;
          if (beats_left_q == 4'd1)
            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (alloc && !commit_ok)
      lq_free_d = lq_free_q - 1'b1;
    else if (!alloc && commit_ok)
      lq_free_d = lq_free_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sb_free_q    <= '1;
      sb_id_q      <= '0;
      lq_head_q    <= '0;
      lq_free_q    <= LQC_W'(LQ_DEPTH);
      beats_left_q <= '0;
      beat_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      sb_free_q    <= sb_free_d;
      sb_id_q      <= sb_id_d;
      lq_head_q    <= lq_head_d;
      lq_free_q    <= lq_free_d;
      beats_left_q <= beats_left_d;
      beat_idx_q   <= beat_idx_d;
    end
  end

  assign o_sb_id         = sb_id_q;
  assign o_lqalloc       = alloc;
  assign o_lqnxtid       = lq_head_q;
  assign o_first_alloc   = alloc && (beat_idx_q == 4'd0);
  assign o_last_alloc    = alloc && (beats_left_q == 4'd1);
  assign o_sb_free_count = sb_cnt;
  assign o_lq_free_count = lq_free_q;
  assign o_busy          = (state_q == S_ALLOC);

`ifdef TT_ALLOC_CHECK_EN
  logic       dup_release;
  logic       commit_underflow;
  logic [1:0] err_q;

  assign dup_release      = i_completed_valid && sb_free_q[i_completed_sb_id];
  assign commit_underflow = i_lq_commit && (lq_free_q == LQC_W'(LQ_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= '0;
    else
      err_q <= err_q | {commit_underflow, dup_release};
  end

  assign o_err = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!dup_release) else $error("scoreboard ID %0d released while already free", i_completed_sb_id);
      assert (!commit_underflow) else $error("lq commit with all entries already free");
    end
  end
`endif
`else
  assign o_err = '0;
`endif

endmodule
